// File: rtl/i2s_transmitter_pkg.sv
// i2s_transmitter_pkg
//   Shared defaults and FSM state type for the I2S transmitter slice.
//   No ports.
package i2s_transmitter_pkg;

   localparam int unsigned I2S_DATA_WIDTH_DEF  = 16;
   localparam int unsigned I2S_BITS_PER_CH_DEF = 16;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } i2s_state_t;

endpackage

// File: rtl/i2s_transmitter_edge_detect.sv
// i2s_edge_detect
//   Registers one level input (clk_in domain) and flags its edges.
//   Ports:
//     clk_in  system clock
//     reset   asynchronous, active-low
//     sig     level to watch
//     rise    high while sig is 1 and was 0 on the previous clk_in
//     fall    high while sig is 0 and was 1 on the previous clk_in
module i2s_edge_detect
   import i2s_transmitter_pkg::*;
(
   input  logic clk_in,
   input  logic reset,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_q;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) sig_q <= 1'b0;
      else        sig_q <= sig;
   end

   assign rise = sig & ~sig_q;
   assign fall = sig_q & ~sig;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//   Philips I2S serializer fed by external LRCLK/SCLK levels (clk_in domain).
//   Ports:
//     clk_in       system clock
//     reset        asynchronous, active-low
//     lrclk        frame clock level (low = left slot)
//     sclk         bit clock level
//     s_valid      stereo pair offered
//     s_ready      1-entry buffer can accept a pair
//     s_left       left sample, two's complement
//     s_right      right sample, two's complement
//     i2s_sdata    serial data, MSB first, changes after SCLK fall
//     frame_start  1-cycle pulse: new frame loaded
//     underrun     1-cycle pulse: frame started without a sample
//     sync_err     1-cycle pulse: LRCLK edge not aligned to an SCLK fall
module i2s_transmitter
   import i2s_transmitter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = I2S_DATA_WIDTH_DEF,
   parameter int unsigned BITS_PER_CH = I2S_BITS_PER_CH_DEF
)
(
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  lrclk,
   input  logic                  sclk,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_left,
   input  logic [DATA_WIDTH-1:0] s_right,
   output logic                  i2s_sdata,
   output logic                  frame_start,
   output logic                  underrun,
   output logic                  sync_err
);

   localparam int unsigned FRAME_BITS = 2 * BITS_PER_CH;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

   logic lr_rise, lr_fall, sclk_rise, sclk_fall;

   i2s_edge_detect u_lr_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .sig    (lrclk),
      .rise   (lr_rise),
      .fall   (lr_fall)
   );

   i2s_edge_detect u_sclk_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .sig    (sclk),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   i2s_state_t state_q, state_d;

   logic                  buf_full;
   logic [DATA_WIDTH-1:0] buf_left, buf_right;
   logic [FRAME_BITS-1:0] sr;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  cnt_ovf;
   logic [BITS_PER_CH-1:0] left_slot, right_slot;

   logic frame_edge, lr_bad, accept;
   logic do_frame, do_shift, do_desync;

   assign frame_edge = lr_fall & sclk_fall;
   assign lr_bad     = (lr_rise | lr_fall) & ~sclk_fall;
   assign s_ready    = reset & ~buf_full;
   assign accept     = s_valid & s_ready;

   // Each channel left-justified in its slot, zero padded below the LSB.
   always_comb begin
      left_slot  = '0;
      right_slot = '0;
      left_slot[BITS_PER_CH-1 -: DATA_WIDTH]  = buf_left;
      right_slot[BITS_PER_CH-1 -: DATA_WIDTH] = buf_right;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state_q <= WAIT_SYNC;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      do_frame  = 1'b0;
      do_shift  = 1'b0;
      do_desync = 1'b0;
      case (state_q)
         WAIT_SYNC: begin
            if (frame_edge) begin
               state_d  = RUN;
               do_frame = 1'b1;
            end
         end
         RUN: begin
            if (lr_bad) begin
               state_d   = WAIT_SYNC;
               do_desync = 1'b1;
            end else if (frame_edge) begin
               do_frame = 1'b1;
            end else if (sclk_fall) begin
               do_shift = 1'b1;
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         buf_full    <= 1'b0;
         buf_left    <= '0;
         buf_right   <= '0;
         sr          <= '0;
         bit_cnt     <= '0;
         cnt_ovf     <= 1'b0;
         i2s_sdata   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         sync_err    <= 1'b0;

         // A pair accepted on the frame-start cycle lands in the buffer,
         // not in the frame being loaded (s_ready is low whenever full).
         if (do_frame && buf_full) begin
            buf_full <= 1'b0;
         end else if (accept) begin
            buf_full  <= 1'b1;
            buf_left  <= s_left;
            buf_right <= s_right;
         end

         if (do_desync) begin
            sync_err  <= 1'b1;
            i2s_sdata <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            cnt_ovf   <= 1'b0;
         end else if (do_frame) begin
            frame_start <= 1'b1;
            underrun    <= ~buf_full;
            // I2S one-bit delay: the frame edge still carries the previous
            // right slot's last bit; nothing precedes the first synced frame.
            i2s_sdata   <= (state_q == RUN) ? (sr[FRAME_BITS-1] & ~cnt_ovf) : 1'b0;
            sr          <= buf_full ? {left_slot, right_slot} : '0;
            bit_cnt     <= '0;
            cnt_ovf     <= 1'b0;
         end else if (do_shift) begin
            i2s_sdata <= cnt_ovf ? 1'b0 : sr[FRAME_BITS-1];
            sr        <= {sr[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) cnt_ovf <= 1'b1;
            else                                    bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter
//   Directed bench: models the upstream clock generator (LRCLK 768, SCLK 24
//   clk_in periods), a receiver sampling on SCLK rise, and pulse counters.
module tb_i2s_transmitter;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        lrclk, sclk;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_left, s_right;
   logic        i2s_sdata, frame_start, underrun, sync_err;

   always #5 clk_in = ~clk_in;

   // Clock generator model: LRCLK and SCLK edges coincide at multiples of 24.
   int unsigned gen_cnt = 600;
   logic        lr_inv  = 1'b0;

   always @(posedge clk_in) gen_cnt <= (gen_cnt == 767) ? 0 : gen_cnt + 1;

   assign lrclk = (gen_cnt >= 384) ^ lr_inv;
   assign sclk  = (gen_cnt % 24) >= 12;

   i2s_transmitter #(.DATA_WIDTH(16), .BITS_PER_CH(16)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .lrclk       (lrclk),
      .sclk        (sclk),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_left      (s_left),
      .s_right     (s_right),
      .i2s_sdata   (i2s_sdata),
      .frame_start (frame_start),
      .underrun    (underrun),
      .sync_err    (sync_err)
   );

   // Receiver and pulse counters. rx sampled at SCLK rise; read at cnt 13 it
   // holds {left,right} of the previous frame.
   int unsigned fs_cnt = 0, ur_cnt = 0, se_cnt = 0, hi_cnt = 0;
   logic [31:0] rx = '0;

   always @(negedge clk_in) begin
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (underrun)    ur_cnt <= ur_cnt + 1;
      if (sync_err)    se_cnt <= se_cnt + 1;
      if (i2s_sdata)   hi_cnt <= hi_cnt + 1;
      if ((gen_cnt % 24) == 12) rx <= {rx[30:0], i2s_sdata};
   end

   int unsigned checks = 0, failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cnt(input int unsigned target);
      bit hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_in); #1;
         if (gen_cnt == target) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check_eq("wait_cnt_timeout", 32'(hit), 32'd1);
   endtask

   task automatic push_pair(input logic [15:0] l, input logic [15:0] r,
                            output bit ok, output int unsigned at);
      ok = 1'b0;
      at = 0;
      s_left  = l;
      s_right = r;
      s_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            at = gen_cnt;
            @(negedge clk_in); #1;
            break;
         end
         @(negedge clk_in); #1;
      end
      s_valid = 1'b0;
   endtask

   bit          ok;
   int unsigned at;
   int unsigned fs0, ur0, se0, hi0;

   initial begin
      reset   = 1'b0;
      s_valid = 1'b0;
      s_left  = '0;
      s_right = '0;
      repeat (8) @(negedge clk_in);
      #1;
      check_eq("rst_sdata",    32'(i2s_sdata),   32'd0);
      check_eq("rst_fstart",   32'(frame_start), 32'd0);
      check_eq("rst_underrun", 32'(underrun),    32'd0);
      check_eq("rst_syncerr",  32'(sync_err),    32'd0);
      check_eq("rst_ready",    32'(s_ready),     32'd0);

      reset = 1'b1;
      #1;
      check_eq("ready_after_rst", 32'(s_ready), 32'd1);
      fs0 = fs_cnt;
      ur0 = ur_cnt;

      // First frame carries a pair pushed before sync.
      push_pair(16'hA5C3, 16'h0F0F, ok, at);
      check_eq("push0_ok", 32'(ok), 32'd1);
      check_eq("ready_low_full", 32'(s_ready), 32'd0);
      wait_cnt(13);
      check_eq("f1_fs_once", fs_cnt - fs0, 32'd1);
      check_eq("f1_no_ur",   ur_cnt - ur0, 32'd0);
      check_eq("pre_sync_rx", rx, 32'h0000_0000);
      wait_cnt(13);
      check_eq("f1_data", rx, 32'hA5C3_0F0F);

      // Empty buffer: zero frame with underrun.
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      wait_cnt(13);
      check_eq("f2_zero", rx, 32'h0);
      check_eq("f3_fs",   fs_cnt - fs0, 32'd1);
      check_eq("f3_ur",   ur_cnt - ur0, 32'd1);

      // Three back-to-back pairs, one per frame.
      push_pair(16'h1357, 16'h2468, ok, at);
      check_eq("p1_ok", 32'(ok), 32'd1);
      push_pair(16'h8000, 16'h0001, ok, at);
      check_eq("p2_ok", 32'(ok), 32'd1);
      check_eq("p2_at_fs", at, 32'd1);
      push_pair(16'hFFFF, 16'h7FFE, ok, at);
      check_eq("p3_ok", 32'(ok), 32'd1);
      check_eq("p3_at_fs", at, 32'd1);
      wait_cnt(13);
      check_eq("p1_data", rx, 32'h1357_2468);
      wait_cnt(13);
      check_eq("p2_data", rx, 32'h8000_0001);
      wait_cnt(13);
      check_eq("p3_data", rx, 32'hFFFF_7FFE);

      // Pair offered exactly on the frame-start cycle with buffer empty.
      ur0 = ur_cnt;
      wait_cnt(0);
      push_pair(16'hC0DE, 16'hBEEF, ok, at);
      check_eq("p4_ok", 32'(ok), 32'd1);
      check_eq("p4_at", at, 32'd0);
      wait_cnt(13);
      check_eq("p4_ur",    ur_cnt - ur0, 32'd1);
      check_eq("f7_zero",  rx, 32'h0);
      wait_cnt(13);
      check_eq("p4_not_same_frame", rx, 32'h0);
      wait_cnt(13);
      check_eq("p4_data", rx, 32'hC0DE_BEEF);

      // Reset in the middle of the left slot.
      push_pair(16'hFFFF, 16'h0000, ok, at);
      check_eq("p5_ok", 32'(ok), 32'd1);
      wait_cnt(0);
      wait_cnt(100);
      check_eq("p5_left_bit", 32'(i2s_sdata), 32'd1);
      push_pair(16'h5555, 16'hAAAA, ok, at);
      check_eq("p6_ok", 32'(ok), 32'd1);
      check_eq("p6_full", 32'(s_ready), 32'd0);
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      reset = 1'b0;
      #1;
      check_eq("midrst_sdata", 32'(i2s_sdata), 32'd0);
      check_eq("midrst_ready", 32'(s_ready),   32'd0);
      repeat (5) @(negedge clk_in);
      #1;
      reset = 1'b1;
      #1;
      check_eq("postrst_empty", 32'(s_ready), 32'd1);
      wait_cnt(767);
      check_eq("postrst_no_fs", fs_cnt - fs0, 32'd0);
      wait_cnt(13);
      check_eq("resync_fs", fs_cnt - fs0, 32'd1);
      check_eq("resync_ur", ur_cnt - ur0, 32'd1);

      // Misaligned LRCLK toggle.
      push_pair(16'hFFFF, 16'hFFFF, ok, at);
      check_eq("p7_ok", 32'(ok), 32'd1);
      wait_cnt(0);
      wait_cnt(78);
      check_eq("p7_bit", 32'(i2s_sdata), 32'd1);
      se0 = se_cnt;
      lr_inv = 1'b1;
      wait_cnt(80);
      check_eq("syncerr_pulse", se_cnt - se0, 32'd1);
      check_eq("syncerr_low",   32'(sync_err), 32'd0);
      hi0 = hi_cnt;
      fs0 = fs_cnt;
      push_pair(16'h1234, 16'hABCD, ok, at);
      check_eq("p8_ok", 32'(ok), 32'd1);
      wait_cnt(110);
      lr_inv = 1'b0;
      wait_cnt(767);
      check_eq("syncerr_once",  se_cnt - se0, 32'd1);
      check_eq("desync_quiet",  hi_cnt - hi0, 32'd0);
      check_eq("desync_no_fs",  fs_cnt - fs0, 32'd0);
      wait_cnt(13);
      check_eq("resync2_fs", fs_cnt - fs0, 32'd1);
      wait_cnt(13);
      check_eq("p8_data", rx, 32'h1234_ABCD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
